// File: rtl/shift_operand_queue.sv
// Operand queue in front of the 16-bit barrel shifter: resolves the shift count at push
// time and presents the head entry as In/Cnt/Op, with valid/ready on both sides.
module shift_operand_queue #(
    parameter int DEPTH = 2,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_rs,
    input  logic [DW-1:0]            in_rt,
    input  logic [3:0]               in_imm,
    input  logic                     in_use_imm,
    input  logic [1:0]               in_op,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            sh_in,
    output logic [3:0]               sh_cnt,
    output logic [1:0]               sh_op,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    // Handshake: a transfer happens on a side when its valid and ready are both high at
    // the rising edge and flush is low; ready/valid depend only on registered occupancy.
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] rs_mem  [DEPTH];
    logic [3:0]    cnt_mem [DEPTH];
    logic [1:0]    op_mem  [DEPTH];
    logic          push;
    logic          pop;
    logic [3:0]    resolved_cnt;
    logic          unused_rt_hi;

    assign in_ready     = (occupancy != FULL_OCC);
    assign out_valid    = (occupancy != '0);
    assign push         = in_valid & in_ready & ~flush;
    assign pop          = out_valid & out_ready & ~flush;
    assign resolved_cnt = in_use_imm ? in_imm : in_rt[3:0];
    // Upper Rt bits never reach the shifter, so register counts wrap modulo 16.
    assign unused_rt_hi = ^in_rt[DW-1:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
            rd_ptr    <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occupancy <= occupancy + 1'b1;
            else if (pop && !push) occupancy <= occupancy - 1'b1;
        end
    end

    // Entry storage is deliberately left out of reset; out_valid gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            rs_mem[wr_ptr]  <= in_rs;
            cnt_mem[wr_ptr] <= resolved_cnt;
            op_mem[wr_ptr]  <= in_op;
        end
    end

    assign sh_in  = out_valid ? rs_mem[rd_ptr]  : '0;
    assign sh_cnt = out_valid ? cnt_mem[rd_ptr] : '0;
    assign sh_op  = out_valid ? op_mem[rd_ptr]  : '0;

endmodule

// File: tb/tb_shift_operand_queue.sv
// Bench for shift_operand_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the request stream.
module tb_shift_operand_queue;

    localparam int DEPTH = 2;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_rs;
    logic [DW-1:0] in_rt;
    logic [3:0]    in_imm;
    logic          in_use_imm;
    logic [1:0]    in_op;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] sh_in;
    logic [3:0]    sh_cnt;
    logic [1:0]    sh_op;
    logic [1:0]    occupancy;

    int total = 0;
    int bad   = 0;

    // Reference model entries: {operand, count, op}
    logic [DW+5:0] model_q [$];

    shift_operand_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_op(in_op), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .sh_in(sh_in), .sh_cnt(sh_cnt), .sh_op(sh_op), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW+5:0] head;
        head = (model_q.size() != 0) ? model_q[0] : '0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(model_q.size() != DEPTH));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(model_q.size()));
        check({tag, ".sh_in"},     32'(sh_in),     32'(head[DW+5:6]));
        check({tag, ".sh_cnt"},    32'(sh_cnt),    32'(head[5:2]));
        check({tag, ".sh_op"},     32'(sh_op),     32'(head[1:0]));
    endtask

    // Advance one clock, apply the request-stream rules to the model, then check.
    task automatic tick(input string tag);
        bit       do_push;
        bit       do_pop;
        int       cnt;
        @(posedge clk);
        do_push = in_valid && (model_q.size() < DEPTH) && !flush;
        do_pop  = (model_q.size() > 0) && out_ready && !flush;
        cnt     = in_use_imm ? int'(in_imm) : int'(in_rt) % 16;
        if (flush) begin
            model_q.delete();
        end else begin
            if (do_pop)  model_q.delete(0);
            if (do_push) model_q.push_back({in_rs, 4'(cnt), in_op});
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        in_valid = 1'b0; in_rs = '0; in_rt = '0; in_imm = '0;
        in_use_imm = 1'b0; in_op = '0; flush = 1'b0; out_ready = 1'b0;
    endtask

    task automatic req(input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                       input logic [3:0] imm, input logic use_imm, input logic [1:0] op);
        in_valid = 1'b1; in_rs = rs; in_rt = rt; in_imm = imm;
        in_use_imm = use_imm; in_op = op;
    endtask

    task automatic drain();
        in_valid = 1'b0; flush = 1'b1;
        tick("drain");
        flush = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        check_all("reset");
        #4 rst_n = 1'b1;

        // Immediate count
        req(16'h8001, 16'hFFFF, 4'd1, 1'b1, 2'b01);
        tick("imm");
        check("imm.sh_in_const", 32'(sh_in), 32'h8001);
        check("imm.sh_cnt_const", 32'(sh_cnt), 32'd1);
        check("imm.sh_op_const", 32'(sh_op), 32'd1);
        drain();

        // Register count wraps modulo 16
        req(16'h1234, 16'h0013, 4'd9, 1'b0, 2'b10);
        tick("regwrap");
        check("regwrap.sh_cnt_const", 32'(sh_cnt), 32'h3);
        drain();

        // Full / backpressure with order A,B,C
        out_ready = 1'b0;
        req(16'hAAAA, 16'h0001, 4'd2, 1'b1, 2'b00); tick("full.pushA");
        req(16'hBBBB, 16'h0025, 4'd0, 1'b0, 2'b11); tick("full.pushB");
        check("full.in_ready_const", 32'(in_ready), 32'd0);
        req(16'hCCCC, 16'h0007, 4'd3, 1'b0, 2'b10); tick("full.holdC");
        check("full.occ_const", 32'(occupancy), 32'd2);
        check("full.headA_const", 32'(sh_in), 32'hAAAA);
        out_ready = 1'b1; tick("full.popA");
        check("full.headB_const", 32'(sh_in), 32'hBBBB);
        tick("full.acceptC");
        in_valid = 1'b0;
        check("full.headC_const", 32'(sh_in), 32'hCCCC);
        tick("full.drainC");
        check("full.empty_const", 32'(out_valid), 32'd0);

        // Simultaneous push and pop at occupancy 1
        out_ready = 1'b0;
        req(16'h1111, 16'h0000, 4'd4, 1'b1, 2'b01); tick("sim.fill");
        out_ready = 1'b1;
        req(16'hDDDD, 16'h0000, 4'd5, 1'b1, 2'b11); tick("sim.both");
        check("sim.occ_const", 32'(occupancy), 32'd1);
        check("sim.headD_const", 32'(sh_in), 32'hDDDD);
        drain();

        // Flush with a full queue and an incoming request
        out_ready = 1'b0;
        req(16'h0101, 16'h0001, 4'd1, 1'b1, 2'b00); tick("flush.fill1");
        req(16'h0202, 16'h0002, 4'd2, 1'b1, 2'b01); tick("flush.fill2");
        flush = 1'b1; out_ready = 1'b1;
        req(16'h0303, 16'h0003, 4'd3, 1'b1, 2'b10); tick("flush.edge");
        check("flush.occ_const", 32'(occupancy), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick("flush.after");

        // Asynchronous reset mid-stream with two entries queued
        out_ready = 1'b0;
        req(16'h5A5A, 16'h0004, 4'd4, 1'b1, 2'b01); tick("rst.fill1");
        req(16'hA5A5, 16'h0005, 4'd5, 1'b1, 2'b10); tick("rst.fill2");
        idle();
        #1 rst_n = 1'b0;
        #1;
        model_q.delete();
        check_all("rst.mid");
        check("rst.occ_const", 32'(occupancy), 32'd0);
        #1 rst_n = 1'b1;
        tick("rst.after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_rs      = DW'($urandom);
            in_rt      = DW'($urandom);
            in_imm     = 4'($urandom);
            in_use_imm = 1'($urandom_range(0, 1));
            in_op      = 2'($urandom);
            out_ready  = 1'($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
